lif_neuron_array: RTL and testbench

//   Parametrised array of N leaky integrate-and-fire neurons, stepped in lock-step by a timestep strobe.

---
 rtl/lif_neuron_array_if.sv | 28 ++
 rtl/lif_neuron_array.sv | 122 ++++++++++++
 tb/tb_lif_neuron_array.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/lif_neuron_array_if.sv
// rtl/lif_neuron_array_if.sv - stimulus, config and observation bundle of the LIF neuron array
interface lif_neuron_array_if #(
  parameter int N     = 4,
  parameter int W_IN  = 8,
  parameter int W_MEM = 12,
  parameter int W_CNT = 8,
  parameter int W_SEL = (N > 1) ? $clog2(N) : 1
);
  logic                  en;
  logic [N*W_IN-1:0]     in_current;
  logic                  cfg_we;
  logic [1:0]            cfg_addr;
  logic [W_MEM-1:0]      cfg_data;
  logic [W_SEL-1:0]      mon_sel;
  logic [N-1:0]          spike;
  logic [W_MEM-1:0]      mon_potential;
  logic [W_CNT-1:0]      spike_cnt;

  modport master (
    output en, in_current, cfg_we, cfg_addr, cfg_data, mon_sel,
    input  spike, mon_potential, spike_cnt
  );

  modport slave (
    input  en, in_current, cfg_we, cfg_addr, cfg_data, mon_sel,
    output spike, mon_potential, spike_cnt
  );
endinterface

// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - N leaky integrate-and-fire neurons stepped by a shared timestep strobe
module lif_neuron_array #(
  parameter int N           = 4,
  parameter int W_IN        = 8,
  parameter int W_MEM       = 12,
  parameter int W_REF       = 3,
  parameter int W_CNT       = 8,
  parameter int THRESH_INIT = 100,
  parameter int LEAK_INIT   = 3
) (
  input logic               clk,
  input logic               rst,
  lif_neuron_array_if.slave bus
);
  localparam int W_SUM = W_CNT + $clog2(N + 1);

  logic signed [W_MEM-1:0] v       [N];
  logic signed [W_MEM-1:0] v_nxt   [N];
  logic [W_REF-1:0]        ref_cnt [N];
  logic [W_REF-1:0]        ref_nxt [N];
  logic [N-1:0]            spike_q, spike_nxt;
  logic signed [W_MEM-1:0] mon_q, mon_nxt;
  logic [W_CNT-1:0]        cnt_q, cnt_nxt;
  logic [W_SUM-1:0]        cnt_sum;

  logic signed [W_MEM-1:0] threshold;
  logic [3:0]              leak_shift;
  logic [W_REF-1:0]        refrac_period;
  logic                    mode;

  // Overflow of a (W_MEM+1)-bit sum shows as disagreement of its two top bits.
  function automatic logic signed [W_MEM-1:0] sat(input logic signed [W_MEM:0] x);
    if (x[W_MEM] != x[W_MEM-1])
      sat = x[W_MEM] ? {1'b1, {(W_MEM-1){1'b0}}} : {1'b0, {(W_MEM-1){1'b1}}};
    else
      sat = x[W_MEM-1:0];
  endfunction

  always_comb begin
    logic signed [W_MEM-1:0] vl;
    logic signed [W_MEM-1:0] vn;
    logic [W_IN-1:0]         cur;
    spike_nxt = '0;
    vl        = '0;
    vn        = '0;
    cur       = '0;
    for (int i = 0; i < N; i++) begin
      v_nxt[i]   = v[i];
      ref_nxt[i] = ref_cnt[i];
      if (bus.en) begin
        if (ref_cnt[i] != '0) begin
          ref_nxt[i] = ref_cnt[i] - 1'b1;
        end else begin
          cur = bus.in_current[i*W_IN +: W_IN];
          vl  = (leak_shift == 4'd0) ? v[i] : v[i] - (v[i] >>> leak_shift);
          vn  = sat({vl[W_MEM-1], vl} + {{(W_MEM+1-W_IN){cur[W_IN-1]}}, cur});
          if (vn >= threshold) begin
            spike_nxt[i] = 1'b1;
            v_nxt[i]     = mode ? sat({vn[W_MEM-1], vn} - {threshold[W_MEM-1], threshold})
                                : '0;
            ref_nxt[i]   = refrac_period;
          end else begin
            v_nxt[i] = vn;
          end
        end
      end
    end
  end

  always_comb begin
    cnt_sum = W_SUM'(cnt_q);
    for (int i = 0; i < N; i++)
      cnt_sum = cnt_sum + W_SUM'(spike_nxt[i]);
    if (cnt_sum > W_SUM'({W_CNT{1'b1}}))
      cnt_nxt = '1;
    else
      cnt_nxt = cnt_sum[W_CNT-1:0];
  end

  // Monitor shows the value the selected neuron holds after this edge.
  always_comb begin
    mon_nxt = '0;
    if (int'(bus.mon_sel) < N)
      mon_nxt = v_nxt[bus.mon_sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        v[i]       <= '0;
        ref_cnt[i] <= '0;
      end
      spike_q       <= '0;
      mon_q         <= '0;
      cnt_q         <= '0;
      threshold     <= W_MEM'(THRESH_INIT);
      leak_shift    <= 4'(LEAK_INIT);
      refrac_period <= '0;
      mode          <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        v[i]       <= v_nxt[i];
        ref_cnt[i] <= ref_nxt[i];
      end
      spike_q <= spike_nxt;
      mon_q   <= mon_nxt;
      cnt_q   <= cnt_nxt;
      if (bus.cfg_we) begin
        case (bus.cfg_addr)
          2'd0:    threshold     <= bus.cfg_data;
          2'd1:    leak_shift    <= bus.cfg_data[3:0];
          2'd2:    refrac_period <= bus.cfg_data[W_REF-1:0];
          default: mode          <= bus.cfg_data[0];
        endcase
      end
    end
  end

  assign bus.spike         = spike_q;
  assign bus.mon_potential = mon_q;
  assign bus.spike_cnt     = cnt_q;
endmodule

// File: tb/tb_lif_neuron_array.sv
// tb/tb_lif_neuron_array.sv - directed and randomized checks of lif_neuron_array against a behavioural model
module tb_lif_neuron_array;
  localparam int N = 4, W_IN = 8, W_MEM = 12, W_CNT = 8;
  localparam int VMAX = 2047, VMIN = -2048, CMAX = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lif_neuron_array_if #(.N(N), .W_IN(W_IN), .W_MEM(W_MEM), .W_CNT(W_CNT)) bus ();
  lif_neuron_array dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0, n_err = 0;
  int mv[N], mref[N];
  int thr, leak, rp, mode, cnt, e_spike, e_mon;
  int cur[N];
  int t_en, t_we, t_addr, t_data, t_sel, t_rst;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int x);
    return (x > VMAX) ? VMAX : (x < VMIN) ? VMIN : x;
  endfunction

  task automatic model_edge();
    int vl, vn, pc;
    if (t_rst != 0) begin
      foreach (mv[i]) begin mv[i] = 0; mref[i] = 0; end
      thr = 100; leak = 3; rp = 0; mode = 0; cnt = 0; e_spike = 0; e_mon = 0;
      return;
    end
    e_spike = 0;
    pc = 0;
    if (t_en != 0) begin
      for (int i = 0; i < N; i++) begin
        if (mref[i] > 0) begin
          mref[i]--;
        end else begin
          vl = (leak == 0) ? mv[i] : mv[i] - (mv[i] >>> leak);
          vn = clamp(vl + cur[i]);
          if (vn >= thr) begin
            e_spike |= (1 << i);
            pc++;
            mv[i] = (mode != 0) ? clamp(vn - thr) : 0;
            mref[i] = rp;
          end else begin
            mv[i] = vn;
          end
        end
      end
    end
    cnt = (cnt + pc > CMAX) ? CMAX : cnt + pc;
    e_mon = (t_sel < N) ? mv[t_sel] : 0;
    if (t_we != 0) begin
      case (t_addr)
        0: thr  = ((t_data & 'hFFF) ^ 'h800) - 'h800;
        1: leak = t_data & 'hF;
        2: rp   = t_data & 'h7;
        default: mode = t_data & 1;
      endcase
    end
  endtask

  task automatic tick();
    logic [N*W_IN-1:0] packed_cur;
    for (int i = 0; i < N; i++) packed_cur[i*W_IN +: W_IN] = W_IN'(cur[i]);
    rst            = (t_rst != 0);
    bus.en         = (t_en != 0);
    bus.in_current = packed_cur;
    bus.cfg_we     = (t_we != 0);
    bus.cfg_addr   = 2'(t_addr);
    bus.cfg_data   = W_MEM'(t_data);
    bus.mon_sel    = 2'(t_sel);
    model_edge();
    @(posedge clk);
    #1;
    check("spike", {28'd0, bus.spike}, e_spike);
    check("mon_potential", 32'($signed(bus.mon_potential)), e_mon);
    check("spike_cnt", {24'd0, bus.spike_cnt}, cnt);
  endtask

  task automatic do_reset();
    t_rst = 1; t_en = 0; t_we = 0;
    foreach (cur[i]) cur[i] = 0;
    tick(); tick();
    t_rst = 0;
  endtask

  task automatic cfg(input int addr, input int data);
    t_en = 0; t_we = 1; t_addr = addr; t_data = data;
    tick();
    t_we = 0;
  endtask

  int exp2[4] = '{30, 60, 90, 0};
  int exp3[7] = '{30, 60, 90, 20, 50, 80, 10};
  int exp4[7] = '{30, 60, 90, 0, 0, 0, 30};
  int exp6[8] = '{40, 20, 10, 5, 3, 2, 1, 1};

  initial begin
    t_rst = 0; t_en = 0; t_we = 0; t_addr = 0; t_data = 0; t_sel = 0;
    foreach (cur[i]) cur[i] = 0;

    do_reset();
    check("rst_spike", {28'd0, bus.spike}, 0);
    check("rst_cnt", {24'd0, bus.spike_cnt}, 0);
    check("rst_mon", 32'($signed(bus.mon_potential)), 0);
    cfg(1, 0);
    cur[0] = 99; t_en = 1; tick();
    check("thr_99", {31'd0, bus.spike[0]}, 0);
    do_reset(); cfg(1, 0);
    cur[0] = 100; t_en = 1; tick();
    check("thr_100", {31'd0, bus.spike[0]}, 1);

    do_reset(); cfg(1, 0);
    cur[0] = 30; t_en = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_v0", 32'($signed(bus.mon_potential)), exp2[k]);
      check("t2_spk", {31'd0, bus.spike[0]}, (k == 3) ? 1 : 0);
    end
    t_en = 0; tick();
    check("t2_pulse", {31'd0, bus.spike[0]}, 0);

    do_reset(); cfg(1, 0); cfg(3, 1);
    cur[0] = 30; t_en = 1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("t3_v0", 32'($signed(bus.mon_potential)), exp3[k]);
    end

    do_reset(); cfg(1, 0); cfg(2, 2);
    cur[0] = 30; t_en = 1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("t4_v0", 32'($signed(bus.mon_potential)), exp4[k]);
      check("t4_spk", {31'd0, bus.spike[0]}, (k == 3) ? 1 : 0);
    end

    do_reset(); cfg(1, 0); cfg(0, 2047);
    cur[0] = 127; t_en = 1;
    for (int k = 0; k < 17; k++) begin
      tick();
      if (k == 15) check("t5_2032", 32'($signed(bus.mon_potential)), 2032);
    end
    check("t5_sat_spk", {31'd0, bus.spike[0]}, 1);
    do_reset(); cfg(1, 0);
    cur[1] = -128; t_sel = 1; t_en = 1;
    for (int k = 0; k < 20; k++) tick();
    check("t5_neg_floor", 32'($signed(bus.mon_potential)), -2048);
    t_sel = 0;

    do_reset(); cfg(1, 0);
    cur[0] = 80; t_en = 1; tick();
    cur[0] = 0; cfg(1, 1);
    t_en = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t6_leak", 32'($signed(bus.mon_potential)), exp6[k]);
    end
    cur[0] = 69; t_we = 1; t_addr = 0; t_data = 50; tick();
    t_we = 0;
    check("t6_old_thr", {31'd0, bus.spike[0]}, 0);
    cur[0] = 40; tick();
    check("t6_new_thr", {31'd0, bus.spike[0]}, 1);

    do_reset(); cfg(0, 0);
    t_en = 1;
    for (int k = 0; k < 63; k++) tick();
    check("cnt_252", {24'd0, bus.spike_cnt}, 252);
    cur[2] = -1; cur[3] = -1; tick();
    check("cnt_254", {24'd0, bus.spike_cnt}, 254);
    foreach (cur[i]) cur[i] = 0;
    tick();
    check("cnt_sat", {24'd0, bus.spike_cnt}, 255);

    do_reset();
    for (int k = 0; k < 600; k++) begin
      t_rst  = ($urandom_range(0, 149) == 0);
      t_en   = ($urandom_range(0, 3) != 0);
      t_we   = ($urandom_range(0, 7) == 0);
      t_addr = $urandom_range(0, 3);
      t_data = (t_addr == 0) ? $urandom_range(0, 400) : $urandom_range(0, 4095);
      if (t_addr == 0 && $urandom_range(0, 5) == 0) t_data = $urandom_range(0, 4095);
      t_sel  = $urandom_range(0, N - 1);
      foreach (cur[i]) cur[i] = int'($urandom_range(0, 255)) - 128;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
